// File: rtl/vector_op_sequencer.sv
// Control FSM that walks one scalar or vector operation through a fixed-latency datapath.
// It issues read indices, tracks in-flight elements, emits write-backs and reports completion.
module vector_op_sequencer #(
    parameter int N   = 6,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_type,
    input  logic [N-1:0] vector_max,
    input  logic         stall,
    output logic         busy,
    output logic         rd_en,
    output logic [N-1:0] rd_addr,
    output logic         wr_en,
    output logic [N-1:0] wr_addr,
    output logic [N-1:0] counter,
    output logic         finished,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t         state_q, state_d;
    logic [N-1:0]   len_q, len_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   count_q, count_d;
    logic           finished_q, finished_d;
    logic           err_q, err_d;
    logic [LAT-1:0] pipe_valid_q, pipe_valid_d;
    logic [N-1:0]   pipe_addr_q [LAT];
    logic [N-1:0]   pipe_addr_d [LAT];

    logic           issue_fire;
    logic           write_fire;
    logic [N-1:0]   start_len;

    // A stalled cycle neither issues nor retires, so both strobes are gated by stall directly.
    always_comb begin
        issue_fire = (state_q == ISSUE) && !stall;
        write_fire = pipe_valid_q[LAT-1] && !stall;
        start_len  = op_type ? vector_max : ONE;
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        count_d      = count_q;
        finished_d   = finished_q;
        err_d        = err_q;
        pipe_valid_d = pipe_valid_q;
        pipe_addr_d  = pipe_addr_q;

        // The last stage holds the element due for write-back in this cycle.
        if (!stall) begin
            pipe_valid_d[0] = issue_fire;
            pipe_addr_d[0]  = idx_q;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid_d[i] = pipe_valid_q[i-1];
                pipe_addr_d[i]  = pipe_addr_q[i-1];
            end
        end

        if (write_fire) begin
            count_d = count_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = start_len;
                    idx_d      = '0;
                    count_d    = '0;
                    finished_d = 1'b0;
                    err_d      = 1'b0;
                    if (start_len == '0) begin
                        finished_d = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue_fire) begin
                    idx_d = idx_q + ONE;
                    if (idx_q == len_q - ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (write_fire && (pipe_addr_q[LAT-1] == len_q - ONE)) begin
                    state_d    = IDLE;
                    finished_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            finished_q   <= 1'b0;
            err_q        <= 1'b0;
            pipe_valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            finished_q   <= finished_d;
            err_q        <= err_d;
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < LAT; i++) begin
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    // Addresses read as zero whenever their strobe is low.
    always_comb begin
        busy     = (state_q != IDLE);
        rd_en    = issue_fire;
        rd_addr  = issue_fire ? idx_q : '0;
        wr_en    = write_fire;
        wr_addr  = write_fire ? pipe_addr_q[LAT-1] : '0;
        counter  = count_q;
        finished = finished_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Randomized bench for vector_op_sequencer, checked every cycle against a queue-based
// model where each in-flight element counts down its remaining non-stalled cycles.
module tb_vector_op_sequencer;

    localparam int N   = 6;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_type;
    logic [N-1:0] vector_max;
    logic         stall;
    logic         busy;
    logic         rd_en;
    logic [N-1:0] rd_addr;
    logic         wr_en;
    logic [N-1:0] wr_addr;
    logic [N-1:0] counter;
    logic         finished;
    logic         err;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    // Reference model state: operation bookkeeping plus in-flight elements and their countdowns
    bit mBusy  = 0;
    int mLen   = 0;
    int mIdx   = 0;
    int mCount = 0;
    bit mFin   = 0;
    bit mErr   = 0;
    int qAddr[$];
    int qRem[$];

    vector_op_sequencer #(.N(N), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_type   (op_type),
        .vector_max(vector_max),
        .stall     (stall),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .counter   (counter),
        .finished  (finished),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus loop
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Drives one cycle of inputs, checks outputs against the model, then advances the model over the edge
    task automatic applyStimulus(input bit iStart, input bit iOp, input logic [N-1:0] iVmax,
                                 input bit iStall, input bit iRst);
        bit expRd;
        bit expWr;
        int expRdAddr;
        int expWrAddr;
        bit wasBusy;
        int newLen;

        @(negedge clk);
        start      = iStart;
        op_type    = iOp;
        vector_max = iVmax;
        stall      = iStall;
        rst        = iRst;
        #1;

        expRd     = mBusy && (mIdx < mLen) && !iStall;
        expRdAddr = expRd ? mIdx : 0;
        expWr     = 0;
        expWrAddr = 0;
        if (!iStall && qRem.size() > 0) begin
            if (qRem[0] == 1) begin
                expWr     = 1;
                expWrAddr = qAddr[0];
            end
        end

        checkOutput("busy",     32'(busy),     32'(mBusy));
        checkOutput("rd_en",    32'(rd_en),    32'(expRd));
        checkOutput("rd_addr",  32'(rd_addr),  expRdAddr);
        checkOutput("wr_en",    32'(wr_en),    32'(expWr));
        checkOutput("wr_addr",  32'(wr_addr),  expWrAddr);
        checkOutput("counter",  32'(counter),  mCount);
        checkOutput("finished", 32'(finished), 32'(mFin));
        checkOutput("err",      32'(err),      32'(mErr));

        wasBusy = mBusy;
        if (iRst) begin
            mBusy  = 0;
            mLen   = 0;
            mIdx   = 0;
            mCount = 0;
            mFin   = 0;
            mErr   = 0;
            qAddr.delete();
            qRem.delete();
        end else begin
            if (expWr) begin
                mCount++;
                if (qAddr[0] == mLen - 1) begin
                    mBusy = 0;
                    mFin  = 1;
                end
            end
            if (!iStall) begin
                foreach (qRem[i]) qRem[i] = qRem[i] - 1;
                if (qRem.size() > 0 && qRem[0] == 0) begin
                    void'(qRem.pop_front());
                    void'(qAddr.pop_front());
                end
            end
            if (expRd) begin
                qAddr.push_back(mIdx);
                qRem.push_back(LAT);
                mIdx++;
            end
            if (!wasBusy && iStart) begin
                newLen = iOp ? int'(iVmax) : 1;
                mLen   = newLen;
                mIdx   = 0;
                mCount = 0;
                mFin   = 0;
                mErr   = 0;
                if (newLen == 0) begin
                    mFin = 1;
                    mErr = 1;
                end else begin
                    mBusy = 1;
                end
            end
        end
        cyc++;
    endtask

    // Runs one command to completion and checks its length, duration and final flags
    task automatic runOp(input bit op, input logic [N-1:0] vmax, input bit startStall,
                         input int stallPct, input int strayPct, input logic [31:0] stallMask);
        int len;
        int n;
        int stalls;
        bit s;

        len = op ? int'(vmax) : 1;
        applyStimulus(1'b1, op, vmax, startStall, 1'b0);
        n      = 0;
        stalls = 0;
        while (mBusy && n < 400) begin
            s = ((n < 32) && stallMask[n % 32]) || ($urandom_range(0, 99) < stallPct);
            if (s) stalls++;
            applyStimulus($urandom_range(0, 99) < strayPct, 1'($urandom_range(0, 1)),
                          N'($urandom), s, 1'b0);
            n++;
        end
        if (mBusy) checkOutput("opTimeout", 32'd1, 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("opCycles",   n, (len == 0) ? 0 : len + LAT + stalls);
        checkOutput("opCounter",  32'(counter),  len);
        checkOutput("opFinished", 32'(finished), 32'd1);
        checkOutput("opErr",      32'(err),      (len == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        op_type    = 1'b0;
        vector_max = '0;
        stall      = 1'b0;
        repeat (2) @(posedge clk);

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

        runOp(1'b0, 6'd20, 1'b0, 0, 0, 32'h0);
        runOp(1'b1, 6'd5,  1'b0, 0, 0, 32'h0);
        runOp(1'b1, 6'd4,  1'b0, 0, 0, 32'hC);
        runOp(1'b1, 6'd0,  1'b0, 0, 0, 32'h0);

        applyStimulus(1'b1, 1'b1, 6'd10, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("rstBusy",     32'(busy),     32'd0);
        checkOutput("rstRdEn",     32'(rd_en),    32'd0);
        checkOutput("rstWrEn",     32'(wr_en),    32'd0);
        checkOutput("rstCounter",  32'(counter),  32'd0);
        checkOutput("rstFinished", 32'(finished), 32'd0);
        repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        runOp(1'b1, 6'd3, 1'b0, 0, 0, 32'h0);

        runOp(1'b1, 6'd10, 1'b0, 0, 100, 32'h0);
        runOp(1'b1, 6'd2,  1'b1, 0, 0, 32'h5);
        runOp(1'b1, 6'd63, 1'b0, 10, 5, 32'h0);

        repeat (4) applyStimulus(1'b0, 1'($urandom_range(0, 1)), N'($urandom),
                                 1'($urandom_range(0, 1)), 1'b0);

        for (int k = 0; k < 30; k++) begin
            runOp(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? 6'd63 : N'($urandom_range(0, 12)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 40), 10, 32'h0);
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b1, 1'b1, N'($urandom_range(1, 12)), 1'b0, 1'b0);
                repeat ($urandom_range(0, 6)) applyStimulus(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
                applyStimulus(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), 1'b1);
                applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
